// File: rtl/clarvi_byte_alu_pkg.sv
// Shared types for the byte-serial execute unit.
// Op encoding, FSM states and op-class helpers.
package clarvi_byte_alu_pkg;

  localparam int unsigned PARTS = 8;
  localparam logic [2:0] LAST_PART = 3'(PARTS - 1);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLT  = 3'd5,
    OP_SLTU = 3'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic is_cmp(alu_op_t op);
    return (op == OP_SLT) || (op == OP_SLTU);
  endfunction

  function automatic logic is_sub(alu_op_t op);
    return (op == OP_SUB) || is_cmp(op);
  endfunction

  function automatic logic is_valid(alu_op_t op);
    return op <= OP_SLTU;
  endfunction

endpackage

// File: rtl/clarvi_byte_alu_if.sv
// Decoder request plus byte-sliced register-file ports.
// slave = execute unit, master = decoder/register file side.
interface clarvi_byte_alu_if;
  import clarvi_byte_alu_pkg::*;

  logic        start;
  alu_op_t     op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        use_imm;
  logic [63:0] imm;
  logic        busy;
  logic        done;
  logic [2:0]  fetch_part;
  logic [4:0]  fetch_register_1;
  logic [4:0]  fetch_register_2;
  logic [7:0]  data_out_1;
  logic [7:0]  data_out_2;
  logic [2:0]  write_part;
  logic [4:0]  write_register;
  logic [7:0]  data_in;
  logic        write_enable;

  modport slave (
    input  start, op, rs1, rs2, rd,
    input  use_imm, imm,
    input  data_out_1, data_out_2,
    output busy, done, fetch_part,
    output fetch_register_1, fetch_register_2,
    output write_part, write_register,
    output data_in, write_enable
  );

  modport master (
    output start, op, rs1, rs2, rd,
    output use_imm, imm,
    output data_out_1, data_out_2,
    input  busy, done, fetch_part,
    input  fetch_register_1, fetch_register_2,
    input  write_part, write_register,
    input  data_in, write_enable
  );

endinterface

// File: rtl/clarvi_byte_alu_slice.sv
// One byte of the datapath: adder with carry chain
// plus bitwise ops; sign bits feed the SLT decision.
module clarvi_byte_alu_slice
  import clarvi_byte_alu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       carry_i,
  input  alu_op_t    op_i,
  output logic [7:0] result_o,
  output logic       carry_o,
  output logic       a_sign_o,
  output logic       b_sign_o,
  output logic       sum_sign_o
);

  logic [7:0] bx;
  logic [8:0] sum;

  assign bx = is_sub(op_i) ? ~b_i : b_i;
  assign sum = {1'b0, a_i} + {1'b0, bx}
             + {8'd0, carry_i};

  assign carry_o    = sum[8];
  assign a_sign_o   = a_i[7];
  assign b_sign_o   = b_i[7];
  assign sum_sign_o = sum[7];

  always_comb begin
    result_o = sum[7:0];
    unique case (1'b1)
      op_i == OP_AND: result_o = a_i & b_i;
      op_i == OP_OR:  result_o = a_i | b_i;
      op_i == OP_XOR: result_o = a_i ^ b_i;
      default:        result_o = sum[7:0];
    endcase
  end

endmodule

// File: rtl/clarvi_byte_alu.sv
// Byte-serial 64-bit execute unit: walks parts 0..7,
// writing each result byte straight into the register file.
module clarvi_byte_alu
  import clarvi_byte_alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  clarvi_byte_alu_if.slave   bus
);

  state_t      state_q;
  logic [2:0]  k_q;
  alu_op_t     op_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic        use_imm_q;
  logic [63:0] imm_q;
  logic        carry_q;
  logic        lt_q;
  logic        done_q;

  logic [7:0] b_byte;
  logic [7:0] result;
  logic       carry_out;
  logic       a_sign;
  logic       b_sign;
  logic       sum_sign;
  logic       lt_d;

  assign b_byte = use_imm_q ? imm_q[{k_q, 3'b000} +: 8]
                            : bus.data_out_2;

  clarvi_byte_alu_slice u_slice (
    .a_i        (bus.data_out_1),
    .b_i        (b_byte),
    .carry_i    (carry_q),
    .op_i       (op_q),
    .result_o   (result),
    .carry_o    (carry_out),
    .a_sign_o   (a_sign),
    .b_sign_o   (b_sign),
    .sum_sign_o (sum_sign)
  );

  assign lt_d = (op_q == OP_SLTU) ? ~carry_out
              : (a_sign != b_sign) ? a_sign
              : sum_sign;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      op_q      <= OP_ADD;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      carry_q   <= 1'b0;
      lt_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q      <= bus.op;
            rs1_q     <= bus.rs1;
            rs2_q     <= bus.rs2;
            rd_q      <= bus.rd;
            use_imm_q <= bus.use_imm;
            imm_q     <= bus.imm;
            k_q       <= '0;
            carry_q   <= is_sub(bus.op);
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          carry_q <= carry_out;
          k_q     <= k_q + 3'd1;
          if (k_q == LAST_PART) begin
            lt_q <= lt_d;
            if (is_cmp(op_q)) begin
              state_q <= S_FIX;
            end else begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // k_q wraps to 0 after part 7, so FIX writes part 0 as well
  assign bus.fetch_part       = k_q;
  assign bus.write_part       = k_q;
  assign bus.fetch_register_1 = rs1_q;
  assign bus.fetch_register_2 = rs2_q;
  assign bus.write_register   = rd_q;
  assign bus.busy             = state_q != S_IDLE;
  assign bus.done             = done_q;

  always_comb begin
    bus.write_enable = 1'b0;
    bus.data_in      = 8'd0;
    unique case (state_q)
      S_RUN: begin
        if (is_valid(op_q)) begin
          if (is_cmp(op_q)) begin
            bus.write_enable = k_q != 3'd0;
          end else begin
            bus.write_enable = 1'b1;
            bus.data_in      = result;
          end
        end
      end
      S_FIX: begin
        bus.write_enable = 1'b1;
        bus.data_in      = {7'd0, lt_q};
      end
      default: ;
    endcase
    // reset blocks the write of the edge that aborts
    if (reset || rd_q == 5'd0)
      bus.write_enable = 1'b0;
  end

endmodule

// File: tb/tb_clarvi_byte_alu.sv
// Directed bench for clarvi_byte_alu with a
// behavioural byte-sliced register file.
module tb_clarvi_byte_alu;
  import clarvi_byte_alu_pkg::*;

  logic clock;
  logic reset;
  clarvi_byte_alu_if bus ();

  clarvi_byte_alu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [63:0] rf [32];
  logic        ld_en;
  logic [4:0]  ld_idx;
  logic [63:0] ld_val;

  assign bus.data_out_1 = (bus.fetch_register_1 == 5'd0) ? 8'd0
    : rf[bus.fetch_register_1][{bus.fetch_part, 3'b000} +: 8];
  assign bus.data_out_2 = (bus.fetch_register_2 == 5'd0) ? 8'd0
    : rf[bus.fetch_register_2][{bus.fetch_part, 3'b000} +: 8];

  always @(posedge clock) begin
    if (ld_en)
      rf[ld_idx] <= ld_val;
    else if (bus.write_enable && bus.write_register != 5'd0)
      rf[bus.write_register][{bus.write_part, 3'b000} +: 8]
        <= bus.data_in;
  end

  int total = 0;
  int bad = 0;
  int wc;
  bit w0;
  bit seen;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] idx,
                      input logic [63:0] val);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic start_op(input alu_op_t o,
                          input logic [4:0] s1, s2, d,
                          input logic ui,
                          input logic [63:0] im);
    bus.op = o; bus.rs1 = s1; bus.rs2 = s2; bus.rd = d;
    bus.use_imm = ui; bus.imm = im; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // called in cycle c0 of an operation; returns in its done cycle
  task automatic wait_op(input int c0, input int exp_done,
                         output int wecnt, output bit wr0);
    int cyc;
    bit pbad;
    cyc = c0; wecnt = 0; wr0 = 1'b0; pbad = 1'b0;
    while (!bus.done && cyc < 30) begin
      if (bus.write_enable) begin
        wecnt++;
        if (cyc <= 8 && bus.write_part == 3'd0) wr0 = 1'b1;
      end
      if (cyc <= 8 && bus.fetch_part != 3'(cyc - 1)) pbad = 1'b1;
      @(negedge clock);
      cyc++;
    end
    chk("done_cycle", 64'(cyc), 64'(exp_done));
    chk("part_seq", 64'(pbad), 64'd0);
    chk("busy_in_done", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    bus.start = 1'b0; bus.op = OP_ADD; bus.rs1 = '0;
    bus.rs2 = '0; bus.rd = '0; bus.use_imm = 1'b0; bus.imm = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_we", 64'(bus.write_enable), 64'd0);
    chk("rst_wpart", 64'(bus.write_part), 64'd0);
    chk("rst_fpart", 64'(bus.fetch_part), 64'd0);
    chk("rst_din", 64'(bus.data_in), 64'd0);
    chk("rst_wreg", 64'(bus.write_register), 64'd0);
    chk("rst_freg", 64'({bus.fetch_register_1,
                         bus.fetch_register_2}), 64'd0);
    reset = 1'b0;

    load(1, 64'hFFFF_FFFF_FFFF_FFFF);
    load(2, 64'd1);
    load(3, 64'h5555_5555_5555_5555);
    load(4, 64'h1111_1111_1111_1111);
    load(5, 64'h7777_7777_7777_7777);
    load(6, 64'h0123_4567_89AB_CDEF);
    load(7, 64'hAAAA_AAAA_AAAA_AAAA);
    load(15, 64'h1234);
    load(16, 64'hDEAD_BEEF);

    // ADD wraps to zero
    start_op(OP_ADD, 1, 2, 3, 1'b0, '0);
    chk("add_c1_we", 64'(bus.write_enable), 64'd1);
    wait_op(1, 9, wc, w0);
    chk("add_wecnt", 64'(wc), 64'd8);
    chk("add_x3", rf[3], 64'd0);
    @(negedge clock);
    chk("done_pulse", 64'(bus.done), 64'd0);

    // SUB from x0 by immediate borrows across all bytes
    start_op(OP_SUB, 0, 9, 4, 1'b1, 64'd1);
    wait_op(1, 9, wc, w0);
    chk("sub_x4", rf[4], 64'hFFFF_FFFF_FFFF_FFFF);

    start_op(OP_SLT, 1, 2, 5, 1'b0, '0);
    wait_op(1, 10, wc, w0);
    chk("slt_w0", 64'(w0), 64'd0);
    chk("slt_wecnt", 64'(wc), 64'd8);
    chk("slt_x5", rf[5], 64'd1);

    start_op(OP_SLTU, 1, 2, 5, 1'b0, '0);
    wait_op(1, 10, wc, w0);
    chk("sltu_x5", rf[5], 64'd0);

    start_op(OP_SLTU, 2, 1, 8, 1'b0, '0);
    wait_op(1, 10, wc, w0);
    chk("sltu_x8", rf[8], 64'd1);

    start_op(OP_ADD, 6, 6, 6, 1'b0, '0);
    wait_op(1, 9, wc, w0);
    chk("add_x6", rf[6], 64'h0246_8ACF_1357_9BDE);

    start_op(OP_XOR, 1, 0, 9, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F);
    wait_op(1, 9, wc, w0);
    chk("xor_x9", rf[9], 64'hF0F0_F0F0_F0F0_F0F0);

    start_op(OP_OR, 2, 6, 10, 1'b0, '0);
    wait_op(1, 9, wc, w0);
    chk("or_x10", rf[10], 64'h0246_8ACF_1357_9BDF);

    start_op(OP_AND, 6, 0, 11, 1'b1, 64'hFF00_FF00_FF00_FF00);
    wait_op(1, 9, wc, w0);
    chk("and_x11", rf[11], 64'h0200_8A00_1300_9B00);

    // reset during cycle 4 of an ADD into x7
    start_op(OP_ADD, 1, 2, 7, 1'b0, '0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_c4_we", 64'(bus.write_enable), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_c5_we", 64'(bus.write_enable), 64'd0);
    chk("rst_c5_busy", 64'(bus.busy), 64'd0);
    seen = 1'b0;
    repeat (12) begin
      if (bus.done || bus.write_enable) seen = 1'b1;
      @(negedge clock);
    end
    chk("rst_no_done", 64'(seen), 64'd0);
    chk("rst_x7", rf[7], 64'hAAAA_AAAA_AA00_0000);

    // back-to-back: second start in the done cycle
    start_op(OP_ADD, 2, 0, 12, 1'b1, 64'd2);
    wait_op(1, 9, wc, w0);
    start_op(OP_ADD, 1, 1, 13, 1'b0, '0);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    chk("b2b_we", 64'(bus.write_enable), 64'd1);
    chk("b2b_wpart", 64'(bus.write_part), 64'd0);
    chk("b2b_wreg", 64'(bus.write_register), 64'd13);
    chk("b2b_x12", rf[12], 64'd3);
    wait_op(1, 9, wc, w0);
    chk("b2b_x13", rf[13], 64'hFFFF_FFFF_FFFF_FFFE);

    // start while busy is dropped
    start_op(OP_ADD, 1, 2, 14, 1'b0, '0);
    @(negedge clock);
    @(negedge clock);
    bus.op = OP_SUB; bus.rs1 = 5'd2; bus.rs2 = 5'd2;
    bus.rd = 5'd15; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_op(4, 9, wc, w0);
    @(negedge clock);
    chk("busy_start_idle", 64'(bus.busy), 64'd0);
    chk("busy_x14", rf[14], 64'd0);
    chk("busy_x15", rf[15], 64'h1234);

    // rd = x0: timing kept, nothing written
    start_op(OP_ADD, 1, 2, 0, 1'b0, '0);
    wait_op(1, 9, wc, w0);
    chk("x0_wecnt", 64'(wc), 64'd0);

    // unencoded op
    start_op(alu_op_t'(3'd7), 1, 2, 16, 1'b0, '0);
    wait_op(1, 9, wc, w0);
    chk("bad_op_wecnt", 64'(wc), 64'd0);
    chk("bad_op_x16", rf[16], 64'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
